// File: rtl/sink_arbiter_pkg.sv
// sink_arbiter_pkg: shared widths, FSM state encoding and small helpers for
// the sink arbiter. ADDR_BITS (default flit width) is a define so that the
// surrounding system can override it on the command line.
`ifndef ADDR_BITS
`define ADDR_BITS 8
`endif

package sink_arbiter_pkg;

  // Width of the window counter, per-port counters and throughput fields.
  localparam int THROUGHPUT_W = 26;

  // Width of the burst counter; covers the full BURST range 1..255.
  localparam int BURST_W = 8;

  // Arbiter FSM state encoding.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Next port index after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    if (idx >= n - 32'sd1) begin
      return 32'sd0;
    end else begin
      return idx + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/sink_arbiter_if.sv
// sink_arbiter_if: requester-side and sink-side handshake bundle.
// slave  = arbiter view, master = requesters/sink environment view.
interface sink_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 8
);
  logic [N_PORTS-1:0]        in_req;
  logic [N_PORTS*DATA_W-1:0] in_data;
  logic [N_PORTS-1:0]        in_grant;
  logic                      out_req;
  logic [DATA_W-1:0]         out_data;
  logic                      out_busy;

  modport slave (
    input  in_req, in_data, out_busy,
    output in_grant, out_req, out_data
  );

  modport master (
    output in_req, in_data, out_busy,
    input  in_grant, out_req, out_data
  );
endinterface

// File: rtl/sink_arbiter_rr_pick.sv
// sink_arbiter_rr_pick: combinational round-robin picker. Returns the first
// requesting port at or after ptr, as one-hot grant plus index.
module sink_arbiter_rr_pick #(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = 2
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_PORTS-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
  localparam int SW = IDX_W + 1;

  logic [SW-1:0]    sum_s;
  logic [IDX_W-1:0] j_s;

  // Scan ports in rotated order starting at ptr; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum_s = '0;
    j_s   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      sum_s = {1'b0, ptr} + SW'(i);
      if (sum_s >= SW'(N_PORTS)) begin
        sum_s = sum_s - SW'(N_PORTS);
      end else begin
        sum_s = sum_s;
      end
      j_s = sum_s[IDX_W-1:0];
      if (!any && req[j_s]) begin
        any        = 1'b1;
        grant[j_s] = 1'b1;
        idx        = j_s;
      end else begin
        any = any;
      end
    end
  end
endmodule

// File: rtl/sink_arbiter.sv
// sink_arbiter: shares one flit sink among N_PORTS requesters using
// round-robin arbitration with a bounded burst and a single registered
// output stage. Optional per-port throughput counters are enabled with
// the SINK_ARB_STATS_EN macro; without it port_throughput reads zero.
module sink_arbiter
  import sink_arbiter_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = `ADDR_BITS,
  parameter int BURST   = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  sink_arbiter_if.slave                    bus,
  output logic [N_PORTS*THROUGHPUT_W-1:0]  port_throughput
);
  localparam int                 IDX_W   = $clog2(N_PORTS);
  localparam logic [BURST_W-1:0] BURST_C = BURST_W'(BURST);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic                out_req_q, out_req_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  logic                load_s;
  logic                keep_s;
  logic [IDX_W-1:0]    owner_inc_s;
  logic [IDX_W-1:0]    pick_ptr_s;
  logic [N_PORTS-1:0]  pick_grant_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_any_s;
  logic                grant_any_s;
  logic [IDX_W-1:0]    grant_idx_s;
  logic [N_PORTS-1:0]  grant_s;

  // The output stage can take a new flit when empty or draining this cycle.
  assign load_s      = ~out_req_q | ~bus.out_busy;
  assign owner_inc_s = IDX_W'(wrap_inc(int'(owner_q), N_PORTS));

  // Decide whether the current owner keeps the lock and where a fresh pick starts.
  always_comb begin
    keep_s     = 1'b0;
    pick_ptr_s = ptr_q;
    case (state_q)
      IDLE: begin
        keep_s     = 1'b0;
        pick_ptr_s = ptr_q;
      end
      LOCK: begin
        keep_s     = bus.in_req[owner_q] & (burst_cnt_q < BURST_C);
        pick_ptr_s = owner_inc_s;
      end
      default: begin
        keep_s     = 1'b0;
        pick_ptr_s = ptr_q;
      end
    endcase
  end

  sink_arbiter_rr_pick #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (bus.in_req),
    .ptr   (pick_ptr_s),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  assign grant_any_s = keep_s | pick_any_s;
  assign grant_idx_s = keep_s ? owner_q : pick_idx_s;

  // One-hot grant; suppressed while in reset or while the output stage is stalled.
  always_comb begin
    grant_s = '0;
    if (reset && load_s) begin
      if (keep_s) begin
        grant_s[owner_q] = 1'b1;
      end else begin
        grant_s = pick_grant_s;
      end
    end else begin
      grant_s = '0;
    end
  end

  assign bus.in_grant = grant_s;
  assign bus.out_req  = out_req_q;
  assign bus.out_data = out_data_q;

  // Next-state for the arbiter FSM and output stage; everything holds when load is low.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    out_req_d   = out_req_q;
    out_data_d  = out_data_q;
    if (load_s) begin
      if (keep_s) begin
        burst_cnt_d = burst_cnt_q + BURST_W'(1);
      end else if (pick_any_s) begin
        state_d     = LOCK;
        owner_d     = pick_idx_s;
        burst_cnt_d = BURST_W'(1);
        ptr_d       = pick_ptr_s;
      end else begin
        state_d = IDLE;
        ptr_d   = pick_ptr_s;
      end
      out_req_d = grant_any_s;
      if (grant_any_s) begin
        out_data_d = bus.in_data[int'(grant_idx_s)*DATA_W +: DATA_W];
      end else begin
        out_data_d = out_data_q;
      end
    end else begin
      out_req_d = out_req_q;
    end
  end

  // Arbiter state and output stage registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      out_req_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      out_req_q   <= out_req_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef SINK_ARB_STATS_EN
  logic [THROUGHPUT_W-1:0] win_q, win_d;
  logic [THROUGHPUT_W-1:0] cnt_q [N_PORTS];
  logic [THROUGHPUT_W-1:0] cnt_d [N_PORTS];
  logic [THROUGHPUT_W-1:0] thr_q [N_PORTS];
  logic [THROUGHPUT_W-1:0] thr_d [N_PORTS];
  logic                    latch_s;
  logic [N_PORTS-1:0]      acc_s;

  assign acc_s   = bus.in_req & grant_s;
  assign latch_s = &win_q;

  // Window counter and per-port counts; at window end latch and restart, dropping that cycle's flits.
  always_comb begin
    win_d = win_q;
    for (int i = 0; i < N_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      thr_d[i] = thr_q[i];
    end
    if (latch_s) begin
      win_d = '0;
      for (int i = 0; i < N_PORTS; i++) begin
        cnt_d[i] = '0;
        thr_d[i] = cnt_q[i];
      end
    end else begin
      win_d = win_q + THROUGHPUT_W'(1);
      for (int i = 0; i < N_PORTS; i++) begin
        cnt_d[i] = cnt_q[i] + THROUGHPUT_W'(acc_s[i]);
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q <= '0;
      for (int i = 0; i < N_PORTS; i++) begin
        cnt_q[i] <= '0;
        thr_q[i] <= '0;
      end
    end else begin
      win_q <= win_d;
      for (int i = 0; i < N_PORTS; i++) begin
        cnt_q[i] <= cnt_d[i];
        thr_q[i] <= thr_d[i];
      end
    end
  end

  // Flatten latched per-port throughput onto the output bus.
  always_comb begin
    port_throughput = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      port_throughput[i*THROUGHPUT_W +: THROUGHPUT_W] = thr_q[i];
    end
  end
`else
  assign port_throughput = '0;
`endif

endmodule
